// File: rtl/mem_write_router.sv
// Hack data-port decoder: steers RAM/Screen write strobes, holds LED, UART TX
// byte channel and TX byte counter, and muxes read data back to the CPU.
module mem_write_router #(
  parameter logic [14:0] LED_ADDR  = 15'h6001,
  parameter logic [14:0] UART_ADDR = 15'h6002,
  parameter logic [14:0] CNT_ADDR  = 15'h6003
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [14:0] ADDR,
  input  logic [15:0] DIN,
  input  logic        WRITE,
  output logic [15:0] RDATA,
  output logic        STALL,
  output logic        RAM_LOAD,
  input  logic [15:0] RAM_DOUT,
  output logic        SCREEN_LOAD,
  input  logic [15:0] SCREEN_DOUT,
  input  logic [15:0] KBD,
  output logic [15:0] LED_OUT,
  output logic [7:0]  TX_DATA,
  output logic        TX_VALID,
  input  logic        TX_READY
);

  localparam logic [14:0] KBD_ADDR = 15'h6000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } tx_state_e;

  tx_state_e   state_r;
  logic [15:0] led_r;
  logic [15:0] cnt_r;
  logic [7:0]  tx_data_r;
  logic        tx_valid_r;
  logic [15:0] rdata_s;

  logic is_ram_s;
  logic is_screen_s;
  logic is_kbd_s;
  logic is_led_s;
  logic is_uart_s;
  logic is_cnt_s;
  logic uart_wr_s;
  logic accept_s;
  logic hold_s;

  assign is_ram_s    = (ADDR[14] == 1'b0);
  assign is_screen_s = (ADDR[14:13] == 2'b10);
  assign is_kbd_s    = (ADDR == KBD_ADDR);
  assign is_led_s    = (ADDR == LED_ADDR);
  assign is_uart_s   = (ADDR == UART_ADDR);
  assign is_cnt_s    = (ADDR == CNT_ADDR);

  assign hold_s    = (state_r == ST_HOLD);
  assign uart_wr_s = WRITE & is_uart_s;
  // A UART write lands when nothing is pending or the pending byte leaves at this edge.
  assign accept_s  = uart_wr_s & (~hold_s | TX_READY);

  assign RAM_LOAD    = WRITE & is_ram_s;
  assign SCREEN_LOAD = WRITE & is_screen_s;
  assign STALL       = uart_wr_s & hold_s & ~TX_READY;

  assign LED_OUT  = led_r;
  assign TX_DATA  = tx_data_r;
  assign TX_VALID = tx_valid_r;
  assign RDATA    = rdata_s;

  // Read-data mux selected by the current address.
  always_comb begin
    rdata_s = 16'h0000;
    if (is_ram_s) begin
      rdata_s = RAM_DOUT;
    end else if (is_screen_s) begin
      rdata_s = SCREEN_DOUT;
    end else if (is_kbd_s) begin
      rdata_s = KBD;
    end else if (is_led_s) begin
      rdata_s = led_r;
    end else if (is_uart_s) begin
      rdata_s = {15'd0, hold_s};
    end else if (is_cnt_s) begin
      rdata_s = cnt_r;
    end else begin
      rdata_s = 16'h0000;
    end
  end

  // UART byte channel FSM with registered TX_DATA/TX_VALID.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r    <= ST_IDLE;
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            tx_data_r  <= DIN[7:0];
            tx_valid_r <= 1'b1;
            state_r    <= ST_HOLD;
          end else begin
            tx_valid_r <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (accept_s) begin
            tx_data_r  <= DIN[7:0];
            tx_valid_r <= 1'b1;
            state_r    <= ST_HOLD;
          end else if (TX_READY) begin
            tx_valid_r <= 1'b0;
            state_r    <= ST_IDLE;
          end else begin
            tx_valid_r <= 1'b1;
          end
        end
        default: begin
          tx_valid_r <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  // LED register load.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      led_r <= 16'h0000;
    end else if (WRITE && is_led_s) begin
      led_r <= DIN;
    end else begin
      led_r <= led_r;
    end
  end

  // TX byte counter: wraps naturally, any write to its address clears it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_r <= 16'h0000;
    end else if (WRITE && is_cnt_s) begin
      cnt_r <= 16'h0000;
    end else if (accept_s) begin
      cnt_r <= cnt_r + 16'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: doc/mem_write_router.md
# mem_write_router

Memory-map decoder and write router between the Hack CPU data port (addressM/outM/writeM) and the data-memory targets. It steers write strobes to RAM and Screen and holds the I/O registers: LED, UART TX byte channel, TX counter. It stalls the CPU while a UART byte is still awaiting acceptance. It returns combinational read data to inM.

## Interface
- LED_ADDR, 15'h6001, word address of the LED register (R/W)
- UART_ADDR, 15'h6002, word address of the UART data (W) / status (R) port
- CNT_ADDR, 15'h6003, word address of the TX byte counter (R; any write clears)

- CLK  in  1  system clock; all state updates on rising edge
- RST_N  in  1  reset, asynchronous assert, active-low
- ADDR  in  15  CPU addressM
- DIN  in  16  CPU outM
- WRITE  in  1  CPU writeM
- RDATA  out  16  CPU inM, combinational
- STALL  out  1  CPU must hold current instruction, combinational
- RAM_LOAD  out  1  RAM16K load
- RAM_DOUT  in  16  RAM16K read data
- SCREEN_LOAD  out  1  Screen load
- SCREEN_DOUT  in  16  Screen read data
- KBD  in  16  keyboard scancode
- LED_OUT  out  16  LED register
- TX_DATA  out  8  byte to UART transmitter
- TX_VALID  out  1  TX_DATA valid
- TX_READY  in  1  transmitter accepts byte when TX_VALID & TX_READY at edge

## Operation
- Decode on ADDR: RAM 0x0000–0x3FFF (ADDR[14]=0); Screen 0x4000–0x5FFF; KBD 0x6000; LED/UART/CNT at parameter addresses; everything else unmapped.
- RAM_LOAD = WRITE & RAM region; SCREEN_LOAD = WRITE & Screen region. Both are purely combinational and never gated by STALL.
- Writes to KBD or unmapped addresses are dropped.
- LED: WRITE to LED_ADDR loads DIN into LED_OUT at the edge.
- UART path FSM, two states:
  - IDLE: TX_VALID=0. WRITE to UART_ADDR is accepted: TX_DATA<=DIN[7:0], TX_COUNT+=1, next HOLD. DIN[15:8] is ignored.
  - HOLD: TX_VALID=1. TX_DATA is held stable. On TX_VALID & TX_READY: if WRITE to UART_ADDR in the same cycle, the new byte is accepted (TX_DATA<=DIN[7:0], count+1, stay HOLD); else go to IDLE.
- STALL = WRITE & (ADDR==UART_ADDR) & HOLD & !TX_READY. No other condition stalls.
- TX_COUNT: 16-bit, increments once per accepted byte, wraps 0xFFFF->0x0000. Any WRITE to CNT_ADDR clears it to 0 (DIN ignored).
- RDATA mux by ADDR:
  - RAM region: RAM_DOUT
  - Screen region: SCREEN_DOUT
  - 0x6000: KBD
  - LED_ADDR: LED_OUT
  - UART_ADDR: {15'b0, HOLD}
  - CNT_ADDR: TX_COUNT
  - unmapped: 0x0000
- Reset values (RST_N low, immediate, independent of CLK): LED_OUT=0, TX_DATA=0, TX_VALID=0, FSM=IDLE, TX_COUNT=0. STALL is 0 as a consequence of IDLE.

## Timing
- Decode, RAM_LOAD, SCREEN_LOAD, RDATA and STALL: zero latency, same cycle as ADDR/WRITE.
- LED_OUT and TX_COUNT: visible one edge after the write.
- TX_VALID: rises the cycle after an accepted UART write. It stays high until the edge where TX_READY is sampled high, then falls unless a back-to-back byte is accepted at that same edge.
- Back-to-back writes with TX_READY held high: one byte per cycle, STALL never asserts.
- Stalled write: the CPU holds ADDR/DIN/WRITE. The write is accepted at the first edge where TX_READY=1.
- RST_N asserted mid-HOLD: TX_VALID drops asynchronously and the pending byte is discarded. After release the FSM is IDLE and the first edge may accept a write.
- Nothing changes on the edge where RST_N deasserts if it coincides with CLK. The first state update happens on the next edge.

## Test plan
- Reset and decode: RST_N=0 then release. WRITE=1 in turn at 0x0005, 0x4010, 0x6000, 0x7000.
  - RAM_LOAD=1 only at 0x0005; SCREEN_LOAD=1 only at 0x4010.
  - LED_OUT and TX_COUNT stay 0.
  - RDATA at 0x7000 is 0x0000; at 0x6000 it equals KBD.
- LED: write 0xA5A5 to 0x6001 -> LED_OUT=0xA5A5 next cycle, RDATA at 0x6001 reads 0xA5A5. Assert RST_N=0 asynchronously -> LED_OUT=0 with no clock edge.
- UART stall: TX_READY=0, write 0x1241 then 0x0042 to 0x6002.
  - TX_DATA=0x41, TX_VALID=1; the second write raises STALL=1.
  - Raise TX_READY for one cycle: TX_DATA becomes 0x42, TX_VALID stays 1, STALL=0, TX_COUNT=2.
  - Status read at 0x6002 returns 0x0001.
- Streaming: TX_READY=1, 4 consecutive writes 0x30–0x33 -> STALL never 1, TX_DATA sequence 0x30..0x33 on consecutive cycles, TX_COUNT=4, TX_VALID low one cycle after the last byte.
- Counter wrap/clear: preload by 65535 accepted writes, then one more -> TX_COUNT=0x0000. Write 3 bytes, then WRITE to 0x6003 -> TX_COUNT=0.
- Reset mid-HOLD: TX_READY=0, write 0x55, assert RST_N=0 -> TX_VALID=0 immediately. Release, then write 0x66 -> TX_DATA=0x66, TX_COUNT=1.
